// File: rtl/pingpong_buf.sv
// pingpong_buf: double buffer feeding a downstream N-bit 2-to-1 mux.
// A producer fills one bank while the consumer reads the other. sel picks
// the bank offered to the reader, and rd_avail says that bank is full.
//
// Handshake (write side, strict valid/ready): a word transfers on a rising
// edge where wr_valid && wr_ready. While wr_ready is low, a wr_valid beat is
// ignored. It is not queued, and the producer must present it again.
// Read side: rd_done is a one-cycle release of the bank chosen by sel. It only
// takes effect while rd_avail is high.
module pingpong_buf #(
  parameter int N  = 4,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_valid,
  input  logic [N-1:0]  wr_data,
  output logic          wr_ready,
  input  logic [AW-1:0] rd_addr,
  input  logic          rd_done,
  output logic [N-1:0]  bank0_q,
  output logic [N-1:0]  bank1_q,
  output logic          sel,
  output logic          rd_avail,
  output logic [1:0]    dbg_full,
  output logic          dbg_wr_bank,
  output logic [AW-1:0] dbg_wr_ptr
);

  localparam int DEPTH = 2 ** AW;
  localparam logic [AW-1:0] LAST = {AW{1'b1}};

  logic [N-1:0]  r_bank0 [DEPTH];
  logic [N-1:0]  r_bank1 [DEPTH];
  logic          r_wr_bank;
  logic [AW-1:0] r_wr_ptr;
  logic [1:0]    r_full;
  logic          r_sel;

  logic          w_wr_fire;
  logic          w_wr_last;
  logic          w_rd_fire;
  logic [1:0]    w_full_nxt;

  assign wr_ready  = ~r_full[r_wr_bank];
  assign rd_avail  = r_full[r_sel];
  assign w_wr_fire = wr_valid & wr_ready;
  assign w_wr_last = (r_wr_ptr == LAST);
  assign w_rd_fire = rd_done & rd_avail;

  assign bank0_q = r_bank0[rd_addr];
  assign bank1_q = r_bank1[rd_addr];
  assign sel     = r_sel;

  assign dbg_full    = r_full;
  assign dbg_wr_bank = r_wr_bank;
  assign dbg_wr_ptr  = r_wr_ptr;

  // Next full flags. A completing write and a release always target different
  // banks, because a write needs an empty bank and a release needs a full one.
  always_comb begin
    w_full_nxt = r_full;
    if (w_rd_fire) w_full_nxt[r_sel] = 1'b0;
    if (w_wr_fire && w_wr_last) w_full_nxt[r_wr_bank] = 1'b1;
  end

  // Bank storage: the accepted word goes to the bank currently being filled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_bank0[i] <= '0;
        r_bank1[i] <= '0;
      end
    end else if (w_wr_fire) begin
      if (r_wr_bank) r_bank1[r_wr_ptr] <= wr_data;
      else           r_bank0[r_wr_ptr] <= wr_data;
    end
  end

  // Control state: write pointer and bank, full flags, and the reader's bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_bank <= 1'b0;
      r_wr_ptr  <= '0;
      r_full    <= 2'b00;
      r_sel     <= 1'b0;
    end else begin
      r_full <= w_full_nxt;
      if (w_wr_fire) begin
        // The pointer wraps naturally at DEPTH-1 because DEPTH is a power of two.
        r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_wr_last) r_wr_bank <= ~r_wr_bank;
      end
      if (w_rd_fire) r_sel <= ~r_sel;
    end
  end

endmodule

// File: tb/tb_pingpong_buf.sv
// Testbench for pingpong_buf (N=4, AW=2): directed vectors with a read-side
// scoreboard. Read stimulus pushes expected words, and a negedge monitor pops
// them and compares them with the addressed output.
module tb_pingpong_buf;
  localparam int N  = 4;
  localparam int AW = 2;

  logic          clk;
  logic          rst_n;
  logic          wr_valid;
  logic [N-1:0]  wr_data;
  logic          wr_ready;
  logic [AW-1:0] rd_addr;
  logic          rd_done;
  logic [N-1:0]  bank0_q;
  logic [N-1:0]  bank1_q;
  logic          sel;
  logic          rd_avail;
  logic [1:0]    dbg_full;
  logic          dbg_wr_bank;
  logic [AW-1:0] dbg_wr_ptr;

  // Scoreboard: expected word plus the output it is read from
  // (0 = mux output chosen by sel, 1 = bank0_q, 2 = bank1_q).
  logic [N-1:0] exp_q[$];
  int           src_q[$];
  logic         rd_en;
  int           rd_src;

  int n_cmp;
  int n_bad;

  pingpong_buf #(.N(N), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_addr(rd_addr), .rd_done(rd_done),
    .bank0_q(bank0_q), .bank1_q(bank1_q),
    .sel(sel), .rd_avail(rd_avail),
    .dbg_full(dbg_full), .dbg_wr_bank(dbg_wr_bank), .dbg_wr_ptr(dbg_wr_ptr)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected summary before 100000ns");
    $fatal(1, "watchdog expired");
  end

  // Immediate flag/value comparison
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Driver: one write beat, held across one rising edge
  task automatic write_word(input logic [N-1:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    @(posedge clk); #1;
    wr_valid = 1'b0;
  endtask

  // Driver: one-cycle rd_done pulse
  task automatic pulse_done();
    rd_done = 1'b1;
    @(posedge clk); #1;
    rd_done = 1'b0;
  endtask

  // Driver: one read beat. The expected word goes to the scoreboard.
  task automatic read_one(input int src, input int addr, input logic [N-1:0] exp);
    rd_addr = AW'(addr);
    rd_src  = src;
    exp_q.push_back(exp);
    src_q.push_back(src);
    rd_en   = 1'b1;
    @(posedge clk); #1;
    rd_en   = 1'b0;
  endtask

  // Monitor: compare the addressed output on each negedge of a read beat
  always @(negedge clk) begin
    if (rd_en) begin
      logic [N-1:0] got;
      logic [N-1:0] exp;
      int           s;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL read_underflow: got read beat, expected queued word");
      end else begin
        exp = exp_q.pop_front();
        s   = src_q.pop_front();
        if (s == 0)      got = sel ? bank1_q : bank0_q;
        else if (s == 1) got = bank0_q;
        else             got = bank1_q;
        if (got !== exp) begin
          n_bad++;
          $display("FAIL read src%0d addr%0d: got %0d expected %0d", s, rd_addr, got, exp);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; wr_valid = 1'b0; wr_data = '0;
    rd_addr = '0; rd_done = 1'b0; rd_en = 1'b0; rd_src = 0;
    n_cmp = 0; n_bad = 0;

    // 1. Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_wr_ready", wr_ready, 1);
    check("rst_rd_avail", rd_avail, 0);
    check("rst_sel", sel, 0);
    for (int a = 0; a < 4; a++) begin
      rd_addr = AW'(a); #1;
      check("rst_bank0_q", bank0_q, 0);
      check("rst_bank1_q", bank1_q, 0);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // 2. Fill bank 0
    write_word(4'd5); write_word(4'd10); write_word(4'd6); write_word(4'd13);
    check("fill0_rd_avail", rd_avail, 1);
    check("fill0_sel", sel, 0);
    check("fill0_wr_ready", wr_ready, 1);
    read_one(0, 0, 4'd5); read_one(0, 1, 4'd10);
    read_one(0, 2, 4'd6); read_one(0, 3, 4'd13);

    // 3. Fill bank 1 with no release, then try a write while both banks are full
    write_word(4'd14); write_word(4'd9); write_word(4'd8); write_word(4'd11);
    check("fill1_wr_ready", wr_ready, 0);
    check("fill1_full", dbg_full, 2'b11);
    write_word(4'd7);
    check("stall_wr_ptr", dbg_wr_ptr, 0);
    check("stall_wr_bank", dbg_wr_bank, 0);
    read_one(1, 0, 4'd5);  read_one(1, 1, 4'd10);
    read_one(1, 2, 4'd6);  read_one(1, 3, 4'd13);
    read_one(2, 0, 4'd14); read_one(2, 1, 4'd9);
    read_one(2, 2, 4'd8);  read_one(2, 3, 4'd11);

    // 4. Release bank 0
    pulse_done();
    check("rel0_sel", sel, 1);
    check("rel0_rd_avail", rd_avail, 1);
    check("rel0_wr_ready", wr_ready, 1);
    check("rel0_full", dbg_full, 2'b10);
    read_one(0, 0, 4'd14); read_one(0, 1, 4'd9);
    read_one(0, 2, 4'd8);  read_one(0, 3, 4'd11);
    write_word(4'd1); write_word(4'd2); write_word(4'd15);
    read_one(1, 0, 4'd1); read_one(1, 1, 4'd2); read_one(1, 2, 4'd15);

    // 5. Final write to bank 0 in the same cycle as the release of bank 1
    check("pre_sim_wr_ptr", dbg_wr_ptr, 3);
    wr_valid = 1'b1; wr_data = 4'd2; rd_done = 1'b1;
    @(posedge clk); #1;
    wr_valid = 1'b0; rd_done = 1'b0;
    check("sim_full", dbg_full, 2'b01);
    check("sim_sel", sel, 0);
    check("sim_rd_avail", rd_avail, 1);
    check("sim_wr_bank", dbg_wr_bank, 1);
    check("sim_wr_ptr", dbg_wr_ptr, 0);
    read_one(0, 0, 4'd1); read_one(0, 1, 4'd2);
    read_one(0, 2, 4'd15); read_one(0, 3, 4'd2);

    // 6. Release bank 0. rd_done with nothing offered must be ignored.
    pulse_done();
    check("rel_empty_sel", sel, 1);
    check("rel_empty_rd_avail", rd_avail, 0);
    pulse_done();
    check("ignored_done_sel", sel, 1);
    check("ignored_done_full", dbg_full, 2'b00);
    write_word(4'd3); write_word(4'd4);
    read_one(2, 0, 4'd3); read_one(2, 1, 4'd4);
    rd_addr = '0;
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("arst_wr_ready", wr_ready, 1);
    check("arst_rd_avail", rd_avail, 0);
    check("arst_sel", sel, 0);
    check("arst_bank0_q", bank0_q, 0);
    check("arst_bank1_q", bank1_q, 0);
    check("arst_wr_ptr", dbg_wr_ptr, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    write_word(4'd1); write_word(4'd2); write_word(4'd3); write_word(4'd4);
    check("refill_rd_avail", rd_avail, 1);
    check("refill_sel", sel, 0);
    read_one(0, 0, 4'd1); read_one(0, 1, 4'd2);
    read_one(0, 2, 4'd3); read_one(0, 3, 4'd4);
    read_one(2, 0, 4'd0);

    @(posedge clk); #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
